// File: rtl/twenty_to_five.sv
// Purpose : width-reducing gearbox, one 20-word beat in -> four 5-word beats out,
//           least significant block (words 0..4) first.
// Latency : 1 cycle from din acceptance to first dout_valid; one wide beat per 4 cycles.
// Backpr. : dout/dout_valid hold while dout_ready is low; din_ready only when empty,
//           or when the final block leaves this cycle (no bubble between wide beats).
//
// Parameter:
//   WORD_LEN    bits per word (>= 1)
// Ports:
//   clk         clock, all logic on the rising edge
//   srst        synchronous reset, active-high; forces din_ready low while asserted
//   din         wide beat, word k = din[(k+1)*WORD_LEN-1 : k*WORD_LEN]
//   din_valid   din holds a beat
//   din_ready   beat is taken this cycle (combinational from dout_ready only)
//   dout        current narrow beat, straight from the shift register flops
//   dout_valid  dout holds a beat
//   dout_ready  downstream takes dout this cycle
//
// Optional build macro TWENTY_TO_FIVE_TAG_EN adds:
//   dout_idx    block index 0..3 within the current wide beat
//   dout_last   high on the final block of a wide beat
// Both are meaningful only while dout_valid is high.

module twenty_to_five #(
    parameter int WORD_LEN = 66
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic [20*WORD_LEN-1:0]  din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [5*WORD_LEN-1:0]   dout,
    output logic                    dout_valid,
    input  logic                    dout_ready
`ifdef TWENTY_TO_FIVE_TAG_EN
    ,
    output logic [1:0]              dout_idx,
    output logic                    dout_last
`endif
);

    localparam int BLK_W  = 5 * WORD_LEN;
    localparam int WIDE_W = 20 * WORD_LEN;

    // Encoding equals the number of 5-word blocks still owed downstream.
    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        SEND1 = 3'd1,
        SEND2 = 3'd2,
        SEND3 = 3'd3,
        SEND4 = 3'd4
    } state_t;

    state_t              state;
    logic [WIDE_W-1:0]   sr;
    logic                load;
    logic                drain;

    // A new wide beat fits when nothing is owed, or when the last owed block
    // leaves on this same edge. Deliberately independent of din_valid.
    assign din_ready = !srst && ((state == EMPTY) || ((state == SEND1) && dout_ready));

    assign load  = din_valid && din_ready;
    assign drain = dout_valid && dout_ready;

    assign dout  = sr[BLK_W-1:0];

    always_ff @(posedge clk) begin
        if (srst) begin
            sr         <= '0;
            state      <= EMPTY;
            dout_valid <= 1'b0;
`ifdef TWENTY_TO_FIVE_TAG_EN
            dout_idx   <= 2'd0;
            dout_last  <= 1'b0;
`endif
        end else if (load) begin
            // Load wins over the final-block shift, so SEND1 goes straight to SEND4.
            sr         <= din;
            state      <= SEND4;
            dout_valid <= 1'b1;
`ifdef TWENTY_TO_FIVE_TAG_EN
            dout_idx   <= 2'd0;
            dout_last  <= 1'b0;
`endif
        end else if (drain) begin
            sr <= {{BLK_W{1'b0}}, sr[WIDE_W-1:BLK_W]};
            case (state)
                SEND4: begin
                    state <= SEND3;
`ifdef TWENTY_TO_FIVE_TAG_EN
                    dout_idx  <= 2'd1;
                    dout_last <= 1'b0;
`endif
                end
                SEND3: begin
                    state <= SEND2;
`ifdef TWENTY_TO_FIVE_TAG_EN
                    dout_idx  <= 2'd2;
                    dout_last <= 1'b0;
`endif
                end
                SEND2: begin
                    state <= SEND1;
`ifdef TWENTY_TO_FIVE_TAG_EN
                    dout_idx  <= 2'd3;
                    dout_last <= 1'b1;
`endif
                end
                default: begin
                    // SEND1 with no replacement beat: go idle.
                    state      <= EMPTY;
                    dout_valid <= 1'b0;
`ifdef TWENTY_TO_FIVE_TAG_EN
                    dout_idx   <= 2'd0;
                    dout_last  <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twenty_to_five.sv
// Bench for twenty_to_five (WORD_LEN = 8): directed scenarios plus randomized
// traffic, checked against a queue of outstanding 5-word blocks.

module tb_twenty_to_five;

    localparam int WL = 8;
    localparam int BW = 5 * WL;
    localparam int WW = 20 * WL;

    logic          clk = 1'b0;
    logic          srst;
    logic [WW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [BW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
`ifdef TWENTY_TO_FIVE_TAG_EN
    logic [1:0]    dout_idx;
    logic          dout_last;
`endif

    always #5 clk = ~clk;

    twenty_to_five #(.WORD_LEN(WL)) dut (
        .clk        (clk),
        .srst       (srst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef TWENTY_TO_FIVE_TAG_EN
        ,
        .dout_idx   (dout_idx),
        .dout_last  (dout_last)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: blocks accepted upstream but not yet taken downstream, in order.
    logic [BW-1:0] exp_q[$];
    bit            expect_zero;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] ramp(input logic [7:0] base);
        logic [WW-1:0] r;
        for (int k = 0; k < 20; k++) r[k*WL +: WL] = base + 8'(k);
        return r;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check outputs
    // against the reference, then advance the reference to the next edge.
    task automatic step(input logic rst, input logic dv, input logic [WW-1:0] d,
                        input logic dr, output logic took);
        logic rdy_m;
        int   n;
        @(negedge clk);
        srst       = rst;
        din_valid  = dv;
        din        = d;
        dout_ready = dr;
        #1;
        n     = exp_q.size();
        rdy_m = !rst && ((n == 0) || ((n == 1) && dr));
        check("din_ready", 64'(din_ready), 64'(rdy_m));
        check("dout_valid", 64'(dout_valid), 64'(n != 0));
        if (n != 0) begin
            check("dout", 64'(dout), 64'(exp_q[0]));
`ifdef TWENTY_TO_FIVE_TAG_EN
            check("dout_idx", 64'(dout_idx), 64'(4 - n));
            check("dout_last", 64'(dout_last), 64'(n == 1));
`endif
        end else if (expect_zero) begin
            check("dout_reset", 64'(dout), 64'd0);
`ifdef TWENTY_TO_FIVE_TAG_EN
            check("idx_reset", 64'(dout_idx), 64'd0);
            check("last_reset", 64'(dout_last), 64'd0);
`endif
        end
        took = dv && rdy_m;
        if (rst) begin
            exp_q.delete();
            expect_zero = 1'b1;
        end else begin
            if ((n != 0) && dr) void'(exp_q.pop_front());
            if (took) begin
                for (int b = 0; b < 4; b++) exp_q.push_back(d[b*BW +: BW]);
                expect_zero = 1'b0;
            end
        end
    endtask

    // Hold a beat on din until taken; a stuck din_ready is a failure, not a hang.
    task automatic offer(input logic [WW-1:0] d, input logic dr, output int waited);
        logic took;
        waited = 0;
        do begin
            step(1'b0, 1'b1, d, dr, took);
            waited++;
        end while (!took && waited < 20);
        if (!took) begin
            errors++;
            $display("FAIL offer_timeout: din not taken after %0d cycles", waited);
        end
    endtask

    task automatic idle(input int cycles, input logic dr);
        logic took;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, dr, took);
    endtask

    initial begin
        logic          took;
        int            waited;
        logic [WW-1:0] pend;
        bit            have;
        logic          rst_r;
        logic          dr_r;

        srst       = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        expect_zero = 1'b1;

        // Reset state, then basic: words k = k, dout_ready high throughout.
        idle(2, 1'b1);
        offer(ramp(8'h00), 1'b1, waited);
        @(posedge clk);
        #1;
        check("basic_first_blk", 64'(dout), 64'h0403020100);
        idle(6, 1'b1);

        // Back-to-back: B must load on the cycle A's final block leaves.
        offer(ramp(8'h00), 1'b1, waited);
        offer(ramp(8'h20), 1'b1, waited);
        check("b2b_wait", 64'(waited), 64'd4);
        idle(6, 1'b1);

        // Backpressure on the second block.
        offer(ramp(8'h00), 1'b1, waited);
        step(1'b0, 1'b0, '0, 1'b1, took);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Reset after the first block has gone; a new beat restarts from block 0.
        offer(ramp(8'h40), 1'b1, waited);
        step(1'b0, 1'b0, '0, 1'b1, took);
        step(1'b1, 1'b1, ramp(8'h60), 1'b1, took);
        idle(2, 1'b1);
        offer(ramp(8'h80), 1'b1, waited);
        idle(6, 1'b1);

        // Random traffic with random valid/ready and occasional reset.
        have = 1'b0;
        pend = '0;
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 199) == 0);
            if (!have) begin
                have = ($urandom_range(0, 2) != 0);
                for (int k = 0; k < 20; k++) pend[k*WL +: WL] = 8'($urandom);
            end
            dr_r = ($urandom_range(0, 3) != 0);
            step(rst_r, have, pend, dr_r, took);
            if (took) have = 1'b0;
        end
        idle(8, 1'b1);
        check("final_empty", 64'(dout_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
